// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART FIFO controller.
package uart_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      WAIT_D  = 3'd2,
      LOAD    = 3'd3,
      WAIT_TI = 3'd4,
      GAP     = 3'd5
   } rd_state_e;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned SAT_W     = 32;

   // Increment that sticks at the all-ones value of a counter `width` bits wide.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input int unsigned     width);
      logic [SAT_W-1:0] max_v;
      max_v = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
      return (val >= max_v) ? max_v : val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/uart_fifo_wr_capture.sv
// Write-side capture: turns user requests into FIFO write increments and
// accounts for requests dropped because the FIFO was full.
module uart_fifo_wr_capture
   import uart_fifo_pkg::*;
#(
   parameter int unsigned EN_MODE = 0,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             en,
   input  logic             full,
   input  logic             clr_stat,
   output logic             winc,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] drop_cnt
);

   logic             en_q;
   logic             winc_q, winc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             req;
   logic             drop_ev;

   // Request qualification; a clear lands first so a same-cycle drop still counts.
   always_comb begin
      req     = (EN_MODE != 0) ? en : (en & ~en_q);
      drop_ev = req & full;
      winc_d  = req & ~full;
      drop_d  = drop_q;
      ovf_d   = ovf_q;
      if (clr_stat) begin
         drop_d = drop_ev ? CNT_W'(1) : '0;
         ovf_d  = drop_ev;
      end else if (drop_ev) begin
         drop_d = CNT_W'(sat_inc(SAT_W'(drop_q), CNT_W));
         ovf_d  = 1'b1;
      end
   end

   // History starts high so an en held through reset is not seen as an edge.
   always_ff @(posedge clock) begin
      if (rst) begin
         en_q   <= 1'b1;
         winc_q <= 1'b0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         en_q   <= en;
         winc_q <= winc_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   assign winc       = winc_q;
   assign ovf_sticky = ovf_q;
   assign drop_cnt   = drop_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO controller: write capture plus the read/transmit sequencer that
// drains the FIFO into the UART transmitter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for data (empty=0) and tx_enable
//   RD      | rinc pulse, pops one word
//   WAIT_D  | RD_LAT cycles of FIFO read latency
//   LOAD    | WR pulse, UART samples rdata
//   WAIT_TI | waiting for TI, bounded by TI_TIMEOUT counted from the WR cycle
//   GAP     | GAP_CYC idle cycles between frames
module uart_fifo_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int unsigned EN_MODE    = 0,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned GAP_CYC    = 0,
   parameter int unsigned TI_TIMEOUT = 1_000_000,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             en,
   input  logic             full,
   input  logic             empty,
   input  logic             TI,
   input  logic             tx_enable,
   input  logic             clr_stat,
   output logic             winc,
   output logic             rinc,
   output logic             WR,
   output logic             busy,
   output logic             ovf_sticky,
   output logic             to_sticky,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] tx_cnt
);

   rd_state_e        state_q, state_d;
   logic [31:0]      dly_q, dly_d;
   logic [31:0]      tmo_q, tmo_d;
   logic             tx_ev, to_ev;
   logic             to_q, to_d;
   logic [CNT_W-1:0] tx_q, tx_d;

   uart_fifo_wr_capture #(
      .EN_MODE (EN_MODE),
      .CNT_W   (CNT_W)
   ) u_wr_capture (
      .clock      (clock),
      .rst        (rst),
      .en         (en),
      .full       (full),
      .clr_stat   (clr_stat),
      .winc       (winc),
      .ovf_sticky (ovf_sticky),
      .drop_cnt   (drop_cnt)
   );

   // Next state; tmo runs from the LOAD cycle so it equals cycles since WR.
   always_comb begin
      state_d = state_q;
      dly_d   = '0;
      tmo_d   = '0;
      tx_ev   = 1'b0;
      to_ev   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && tx_enable) state_d = RD;
         end
         RD: begin
            state_d = WAIT_D;
         end
         WAIT_D: begin
            if (dly_q == RD_LAT - 32'd1) state_d = LOAD;
            else                         dly_d   = dly_q + 32'd1;
         end
         LOAD: begin
            state_d = WAIT_TI;
            tmo_d   = tmo_q + 32'd1;
         end
         WAIT_TI: begin
            tmo_d = tmo_q + 32'd1;
            if (TI)                                          tx_ev = 1'b1;
            else if ((TI_TIMEOUT != 0) && (tmo_d >= TI_TIMEOUT)) to_ev = 1'b1;
            if (tx_ev || to_ev) state_d = (GAP_CYC == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (dly_q == GAP_CYC - 32'd1) state_d = IDLE;
            else                          dly_d   = dly_q + 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Transmit statistics; a clear lands first so a same-cycle event still counts.
   always_comb begin
      tx_d = tx_q;
      to_d = to_q;
      if (clr_stat) begin
         tx_d = tx_ev ? CNT_W'(1) : '0;
         to_d = to_ev;
      end else begin
         if (tx_ev) tx_d = CNT_W'(sat_inc(SAT_W'(tx_q), CNT_W));
         if (to_ev) to_d = 1'b1;
      end
   end

   // State, delay/timeout counters and statistics registers.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= IDLE;
         dly_q   <= '0;
         tmo_q   <= '0;
         tx_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         tmo_q   <= tmo_d;
         tx_q    <= tx_d;
         to_q    <= to_d;
      end
   end

   assign rinc      = (state_q == RD);
   assign WR        = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign to_sticky = to_q;
   assign tx_cnt    = tx_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: two configurations driven by the same stimulus,
// each compared every cycle against a timeline model of the frame sequence.
module tb_uart_fifo_ctrl;

   logic clock = 1'b0;
   logic rst, en, full, empty, ti, tx_en, clr;

   logic        winc0, rinc0, wr0, busy0, ovf0, tos0;
   logic [15:0] drop0, tx0;
   logic        winc1, rinc1, wr1, busy1, ovf1, tos1;
   logic [3:0]  drop1, tx1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mvalid = 0;

   // model state, index 0/1 per instance
   bit m_prev[2], m_act[2], m_ovf[2], m_tos[2];
   int m_drop[2], m_tx[2], m_rd[2], m_wr[2], m_idle[2];
   bit e_winc[2], e_rinc[2], e_wr[2], e_busy[2];

   uart_fifo_ctrl #(.EN_MODE(0), .RD_LAT(2), .GAP_CYC(3), .TI_TIMEOUT(20), .CNT_W(16)) dut0 (
      .clock(clock), .rst(rst), .en(en), .full(full), .empty(empty), .TI(ti),
      .tx_enable(tx_en), .clr_stat(clr), .winc(winc0), .rinc(rinc0), .WR(wr0),
      .busy(busy0), .ovf_sticky(ovf0), .to_sticky(tos0), .drop_cnt(drop0), .tx_cnt(tx0));

   uart_fifo_ctrl #(.EN_MODE(1), .RD_LAT(1), .GAP_CYC(0), .TI_TIMEOUT(5), .CNT_W(4)) dut1 (
      .clock(clock), .rst(rst), .en(en), .full(full), .empty(empty), .TI(ti),
      .tx_enable(tx_en), .clr_stat(clr), .winc(winc1), .rinc(rinc1), .WR(wr1),
      .busy(busy1), .ovf_sticky(ovf1), .to_sticky(tos1), .drop_cnt(drop1), .tx_cnt(tx1));

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   // Model of one instance for the cycle that ends at this edge (cur).
   task automatic model_step(input int i);
      int cur, lat, gap, tmo, max_v;
      bit req, dev, tev, oev;
      cur   = cyc;
      lat   = (i == 0) ? 2 : 1;
      gap   = (i == 0) ? 3 : 0;
      tmo   = (i == 0) ? 20 : 5;
      max_v = (i == 0) ? 65535 : 15;
      if (rst) begin
         m_prev[i] = 1'b1; m_act[i] = 1'b0; m_idle[i] = cur + 1;
         m_drop[i] = 0; m_tx[i] = 0; m_ovf[i] = 1'b0; m_tos[i] = 1'b0;
         e_winc[i] = 1'b0; e_rinc[i] = 1'b0; e_wr[i] = 1'b0; e_busy[i] = 1'b0;
         return;
      end
      req       = (i == 1) ? en : (en && !m_prev[i]);
      m_prev[i] = en;
      dev       = req && full;
      e_winc[i] = req && !full;
      if (clr) begin
         m_drop[i] = dev ? 1 : 0;
         m_ovf[i]  = dev;
      end else if (dev) begin
         if (m_drop[i] < max_v) m_drop[i]++;
         m_ovf[i] = 1'b1;
      end
      tev = 1'b0;
      oev = 1'b0;
      if (m_act[i] && cur > m_wr[i]) begin
         if (ti) tev = 1'b1;
         else if (tmo != 0 && (cur - m_wr[i] + 1) >= tmo) oev = 1'b1;
         if (tev || oev) begin
            m_act[i]  = 1'b0;
            m_idle[i] = cur + 1 + gap;
         end
      end
      if (clr) begin
         m_tx[i]  = tev ? 1 : 0;
         m_tos[i] = oev;
      end else begin
         if (tev && m_tx[i] < max_v) m_tx[i]++;
         if (oev) m_tos[i] = 1'b1;
      end
      if (!m_act[i] && cur >= m_idle[i] && !empty && tx_en) begin
         m_act[i] = 1'b1;
         m_rd[i]  = cur + 1;
         m_wr[i]  = cur + 2 + lat;
      end
      e_rinc[i] = m_act[i] && (cur + 1 == m_rd[i]);
      e_wr[i]   = m_act[i] && (cur + 1 == m_wr[i]);
      e_busy[i] = m_act[i] || (cur + 1 < m_idle[i]);
   endtask

   initial forever begin
      @(posedge clock);
      if (rst) mvalid = 1'b1;
      model_step(0);
      model_step(1);
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clock);
      if (mvalid) begin
         chk("d0.winc", 32'(winc0), 32'(e_winc[0]));
         chk("d0.rinc", 32'(rinc0), 32'(e_rinc[0]));
         chk("d0.WR",   32'(wr0),   32'(e_wr[0]));
         chk("d0.busy", 32'(busy0), 32'(e_busy[0]));
         chk("d0.ovf",  32'(ovf0),  32'(m_ovf[0]));
         chk("d0.to",   32'(tos0),  32'(m_tos[0]));
         chk("d0.drop", 32'(drop0), 32'(m_drop[0]));
         chk("d0.tx",   32'(tx0),   32'(m_tx[0]));
         chk("d1.winc", 32'(winc1), 32'(e_winc[1]));
         chk("d1.rinc", 32'(rinc1), 32'(e_rinc[1]));
         chk("d1.WR",   32'(wr1),   32'(e_wr[1]));
         chk("d1.busy", 32'(busy1), 32'(e_busy[1]));
         chk("d1.ovf",  32'(ovf1),  32'(m_ovf[1]));
         chk("d1.to",   32'(tos1),  32'(m_tos[1]));
         chk("d1.drop", 32'(drop1), 32'(m_drop[1]));
         chk("d1.tx",   32'(tx1),   32'(m_tx[1]));
      end
   end

   // Called at a negedge sample point; returns the cycle where the condition holds.
   task automatic wait_sig(input int which, input int budget, output int at);
      bit hit;
      at = -1;
      for (int k = 0; k < budget; k++) begin
         case (which)
            0:       hit = (rinc0 === 1'b1);
            1:       hit = (wr0 === 1'b1);
            2:       hit = (busy0 === 1'b0);
            default: hit = 1'b0;
         endcase
         if (hit) begin
            at = cyc;
            return;
         end
         next_cyc();
         @(negedge clock);
      end
      checks++;
      errors++;
      $display("FAIL wait%0d timed out after %0d cycles at cycle %0d", which, budget, cyc);
   endtask

   initial begin
      int t, w, a, t2, n, ti_pct;
      rst = 1; en = 1; full = 0; empty = 1; ti = 0; tx_en = 0; clr = 0;

      // reset with en held high
      repeat (3) next_cyc();
      rst = 0;
      @(negedge clock);
      chk("rst winc",  32'(winc0), 0);
      chk("rst rinc",  32'(rinc0), 0);
      chk("rst WR",    32'(wr0),   0);
      chk("rst busy",  32'(busy0), 0);
      chk("rst ovf",   32'(ovf0),  0);
      chk("rst to",    32'(tos0),  0);
      chk("rst drop",  32'(drop0), 0);
      chk("rst tx",    32'(tx0),   0);
      chk("rst winc1", 32'(winc1), 0);
      n = 0;
      repeat (5) begin
         next_cyc();
         @(negedge clock);
         if (winc0 === 1'b1) n++;
      end
      chk("en held through reset winc count", 32'(n), 0);

      // edge mode: low 5, high 3
      next_cyc(); en = 0;
      repeat (4) next_cyc();
      next_cyc(); en = 1;
      @(negedge clock); chk("edge cycle winc", 32'(winc0), 0);
      next_cyc(); @(negedge clock); chk("edge+1 winc", 32'(winc0), 1);
      next_cyc(); @(negedge clock); chk("edge+2 winc", 32'(winc0), 0);
      next_cyc(); en = 0; @(negedge clock); chk("edge+3 winc", 32'(winc0), 0);

      // level mode: en 4 cycles, full in cycles 3-4
      next_cyc(); clr = 1;
      next_cyc(); clr = 0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         en   = (k < 4);
         full = (k == 2 || k == 3);
         @(negedge clock);
         if (winc1 === 1'b1) n++;
         next_cyc();
      end
      @(negedge clock);
      chk("level winc count", 32'(n), 2);
      chk("level drop_cnt", 32'(drop1), 2);
      chk("level ovf", 32'(ovf1), 1);

      // frame with TI 10 cycles after WR, then back-to-back frame
      next_cyc(); tx_en = 1; empty = 0;
      @(negedge clock); wait_sig(0, 20, t);
      wait_sig(1, 20, w);
      chk("rinc to WR", 32'(w - t), 3);
      repeat (10) next_cyc();
      ti = 1; a = cyc;
      next_cyc(); ti = 0;
      @(negedge clock); chk("tx_cnt after TI", 32'(tx0), 1);
      wait_sig(0, 20, t2);
      chk("TI accept to next rinc", 32'(t2 - a), 5);
      next_cyc(); tx_en = 0; empty = 1;
      @(negedge clock); wait_sig(1, 20, w);
      next_cyc(); next_cyc(); ti = 1;
      next_cyc(); ti = 0;
      @(negedge clock); wait_sig(2, 20, n);
      chk("tx_cnt second frame", 32'(tx0), 2);

      // timeout
      next_cyc(); clr = 1;
      next_cyc(); clr = 0; tx_en = 1; empty = 0;
      @(negedge clock); wait_sig(0, 20, t);
      next_cyc(); tx_en = 0; empty = 1;
      @(negedge clock); wait_sig(1, 20, w);
      repeat (19) next_cyc();
      @(negedge clock); chk("to_sticky at WR+19", 32'(tos0), 0);
      next_cyc();
      @(negedge clock); chk("to_sticky at WR+20", 32'(tos0), 1);
      chk("tx_cnt after timeout", 32'(tx0), 0);
      wait_sig(2, 20, n);
      chk("timeout to IDLE", 32'(n - w), 23);

      // clear coinciding with a drop
      next_cyc(); full = 1; en = 1;
      next_cyc(); en = 0;
      next_cyc(); en = 1;
      next_cyc(); en = 0;
      @(negedge clock); chk("drop_cnt two drops", 32'(drop0), 2);
      next_cyc(); en = 1; clr = 1;
      next_cyc(); en = 0; clr = 0; full = 0;
      @(negedge clock);
      chk("clr+drop drop_cnt", 32'(drop0), 1);
      chk("clr+drop ovf", 32'(ovf0), 1);

      // reset while waiting for TI
      next_cyc(); tx_en = 1; empty = 0;
      @(negedge clock); wait_sig(0, 20, t);
      next_cyc(); tx_en = 0; empty = 1;
      @(negedge clock); wait_sig(1, 20, w);
      next_cyc(); next_cyc(); rst = 1;
      @(negedge clock); chk("busy in WAIT_TI", 32'(busy0), 1);
      next_cyc(); rst = 0;
      @(negedge clock);
      chk("post-rst busy", 32'(busy0), 0);
      chk("post-rst drop", 32'(drop0), 0);
      chk("post-rst ovf",  32'(ovf0),  0);
      chk("post-rst to",   32'(tos0),  0);
      chk("post-rst tx",   32'(tx0),   0);

      // randomized traffic
      ti_pct = 20;
      for (int k = 0; k < 3000; k++) begin
         next_cyc();
         if (k % 500 == 0) ti_pct = (ti_pct == 20) ? 3 : 20;
         rst   = ($urandom_range(0, 499) == 0);
         en    = ($urandom_range(0, 1) == 1);
         full  = ($urandom_range(0, 9) < 3);
         empty = ($urandom_range(0, 9) < 4);
         ti    = ($urandom_range(0, 99) < ti_pct);
         tx_en = ($urandom_range(0, 99) < 85);
         clr   = ($urandom_range(0, 49) == 0);
      end
      next_cyc();
      rst = 0; en = 0; full = 0; empty = 1; ti = 0; tx_en = 0; clr = 0;
      repeat (3) next_cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Parametrised successor to the UART FIFO controller.
- Converts a request strobe `en` into FIFO write increments (`winc`), guarded by `full`.
- Drains the FIFO into the UART transmitter: pulses `rinc`, waits a configurable FIFO read latency, pulses `WR`, then waits for transmit-done `TI`, with timeout and inter-frame gap.
- Adds edge/level capture modes, drop/transmit statistics, sticky error flags and a transmit gate. Sits between the user logic, the async FIFO and the uart_tx block on DE2-115.

Parameters:
EN_MODE, 0, 0 = one `winc` per rising edge of `en`; 1 = `winc` every cycle `en`=1 and not `full`
RD_LAT, 1, cycles from `rinc` to FIFO data valid (range 1..7)
GAP_CYC, 0, idle cycles inserted after each completed frame (0 = no gap)
TI_TIMEOUT, 1_000_000, max cycles waiting for `TI` after `WR` (0 = timeout disabled)
CNT_W, 16, width of the statistics counters

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  write request from user logic
full  in  1  FIFO full (write-clock domain, already synchronised)
empty  in  1  FIFO empty (already synchronised)
TI  in  1  UART transmit-done, >=1 cycle high
tx_enable  in  1  permits starting new frames
clr_stat  in  1  one-cycle clear of counters and sticky flags
winc  out  1  FIFO write increment
rinc  out  1  FIFO read increment
WR  out  1  UART load strobe (data valid on FIFO rdata)
busy  out  1  read FSM not in IDLE
ovf_sticky  out  1  set when a write request was dropped on `full`
to_sticky  out  1  set on `TI` timeout
drop_cnt  out  CNT_W  dropped write requests, saturating
tx_cnt  out  CNT_W  frames acknowledged by `TI`, saturating

Behaviour:
- Reset (`rst`=1 at a rising `clock` edge):
  - All outputs go to 0, FSM goes to IDLE, counters are cleared.
  - The `en_q` history register resets to 1, so `en` held high through reset produces no edge.
  - Reset aborts any operation immediately, even mid-frame.
- Write side:
  - EN_MODE=0: a request is `en`&~`en_q`. EN_MODE=1: a request is `en`.
  - A request with `full`=0 gives `winc`=1 in the next cycle (registered, 1 cycle latency).
  - A request with `full`=1 gives no `winc`; it sets `ovf_sticky` and increments `drop_cnt`.
- Read FSM: states IDLE, RD, WAIT_D, LOAD, WAIT_TI, GAP.
  - IDLE: if `empty`=0 and `tx_enable`=1, go to RD.
  - RD: `rinc`=1 for exactly one cycle, then WAIT_D.
  - WAIT_D: stay RD_LAT cycles, then LOAD.
  - LOAD: `WR`=1 for exactly one cycle, then WAIT_TI.
  - WAIT_TI: start the timeout counter at 0.
    - `TI`=1 increments `tx_cnt` and goes to GAP, or to IDLE if GAP_CYC=0.
    - Counter reaching TI_TIMEOUT (when nonzero) sets `to_sticky`, does not increment `tx_cnt`, and goes to GAP/IDLE.
  - GAP: stay GAP_CYC cycles, then IDLE.
- Outputs `rinc`, `WR` and `busy` are decoded from the registered state, with no combinational path from the inputs.
- `TI` outside WAIT_TI is ignored. `TI` in the LOAD cycle is ignored; acceptance starts the cycle after `WR`.
- `tx_enable`=0 mid-frame: the current frame completes; no new frame starts.
- `empty` is sampled only in IDLE; `empty` asserting later does not cancel a frame.
- Back-to-back minimum frame period is 3+RD_LAT+GAP_CYC cycles plus the `TI` wait.
- Counters saturate at all-ones.
- `clr_stat` clears counters and sticky flags. An increment event in the same cycle is applied after the clear, so the counter reads 1 and the flag stays set.

Decomposition:
- Package uart_fifo_pkg holds:
  - the FSM state enum: IDLE, RD, WAIT_D, LOAD, WAIT_TI, GAP;
  - default CNT_W;
  - the saturating-increment function.
- One sub-module, uart_fifo_wr_capture: the en history register, EN_MODE select, `winc`/drop/`ovf_sticky` logic and `drop_cnt`.
- Read FSM, timeout counter and `tx_cnt` stay in the top module.

Test Plan:
- Reset with `en`=1 held, release, `en` stays 1 (EN_MODE=0) -> `winc` never asserts; all outputs 0 in the first cycle after reset.
- EN_MODE=0, `en` low 5 cycles then high 3 cycles, `full`=0 -> exactly one `winc` pulse, one cycle after the rising edge.
- EN_MODE=1, `en`=1 for 4 cycles, `full`=1 in cycles 3-4 -> 2 `winc` pulses; `drop_cnt`=2, `ovf_sticky`=1.
- RD_LAT=2, GAP_CYC=3, `empty`=0, `TI` pulsed 10 cycles after `WR`:
  - `rinc` at t, `WR` at t+3;
  - `tx_cnt`=1;
  - next `rinc` no earlier than 3 cycles after `TI` acceptance, plus the IDLE cycle.
- TI_TIMEOUT=20, `TI` never asserted -> `to_sticky`=1 exactly 20 cycles after `WR`; `tx_cnt` unchanged; FSM returns to IDLE.
- `clr_stat` and a `full` drop in the same cycle -> `drop_cnt`=1 and `ovf_sticky`=1 afterwards. `rst` asserted during WAIT_TI -> next cycle `busy`=0, counters 0.
